// File: rtl/minterm_sweeper.sv
// Walks {x,y,w} through all eight minterms of a combinational function under test,
// captures its truth table and compares it against an expected SoP/PoS mask.
module minterm_sweeper #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       pos_mode,
  input  logic [7:0] exp_mask,
  input  logic       f_in,
  output logic [2:0] xyw_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt_out,
  output logic       pass,
  output logic [3:0] mism_cnt,
  output logic [2:0] first_err,
  output logic       err_valid
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SAMPLE,
    ST_FIN
  } state_t;

  // Mismatch counter saturates at the number of minterms.
  function automatic logic [3:0] sat_inc8(input logic [3:0] v);
    return (v >= 4'd8) ? 4'd8 : v + 4'd1;
  endfunction

  state_t     state, state_nxt;
  logic [2:0] idx;
  logic [3:0] settle_cnt;
  logic [7:0] eff_exp;
  logic       mis;
  logic       last;
  logic [3:0] mism_upd;

  assign mis      = (f_in != eff_exp[idx]);
  assign last     = (idx == 3'd7);
  assign mism_upd = mis ? sat_inc8(mism_cnt) : mism_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (abort)                   state_nxt = ST_IDLE;
        else if (settle_cnt <= 4'd1) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)     state_nxt = ST_IDLE;
        else if (last) state_nxt = ST_FIN;
        else           state_nxt = ST_WAIT;
      end
      ST_FIN:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Expected table is data only; it is captured at start and needs no reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) eff_exp <= pos_mode ? ~exp_mask : exp_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 3'd0;
      settle_cnt <= 4'd0;
      xyw_out    <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tt_out     <= 8'd0;
      pass       <= 1'b0;
      mism_cnt   <= 4'd0;
      first_err  <= 3'd0;
      err_valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            tt_out     <= 8'd0;
            mism_cnt   <= 4'd0;
            err_valid  <= 1'b0;
            first_err  <= 3'd0;
            pass       <= 1'b0;
            idx        <= 3'd0;
            xyw_out    <= 3'd0;
            settle_cnt <= SETTLE_LD;
            busy       <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            busy <= 1'b0;
            pass <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_SAMPLE: begin
          // Abort takes priority: the sample in flight is dropped.
          if (abort) begin
            busy <= 1'b0;
            pass <= 1'b0;
          end else begin
            tt_out[idx] <= f_in;
            mism_cnt    <= mism_upd;
            if (mis && !err_valid) begin
              first_err <= idx;
              err_valid <= 1'b1;
            end
            if (last) begin
              busy <= 1'b0;
              done <= 1'b1;
              pass <= (mism_upd == 4'd0);
            end else begin
              idx        <= idx + 3'd1;
              xyw_out    <= idx + 3'd1;
              settle_cnt <= SETTLE_LD;
            end
          end
        end
        ST_FIN: begin
          done <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/minterm_sweeper.md
MINTERM_SWEEPER -- requirements
Module: minterm_sweeper

Interface
REQ-001 Parameter SETTLE_CYC, default 1, cycles xyw_out is held stable before f_in is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one full 8-minterm sweep; honoured only in IDLE.
REQ-005 abort  input  1  cancel a sweep in progress.
REQ-006 pos_mode  input  1  0: exp_mask lists minterms where f=1 (SoP); 1: exp_mask lists maxterms where f=0 (PoS).
REQ-007 exp_mask  input  8  bit i refers to minterm i = {x,y,w}.
REQ-008 f_in  input  1  output of the combinational function under test.
REQ-009 xyw_out  output  3  drives {x,y,w} of the function under test; x is the MSB.
REQ-010 busy  output  1  high while a sweep is active.
REQ-011 done  output  1  one-cycle pulse when a sweep completes normally.
REQ-012 tt_out  output  8  captured truth table; bit i = f_in sampled for minterm i.
REQ-013 pass  output  1  tt_out equals the effective expected table.
REQ-014 mism_cnt  output  4  number of mismatching minterms, 0..8.
REQ-015 first_err  output  3  lowest mismatching minterm index; valid only when err_valid=1.
REQ-016 err_valid  output  1  at least one mismatch was found.

Function
REQ-017 FSM states: IDLE, WAIT, SAMPLE, FIN; all outputs registered.
REQ-018 IDLE with start=1: latch eff_exp = pos_mode ? ~exp_mask : exp_mask; clear tt_out, mism_cnt, err_valid, first_err and pass; set idx=0 and settle counter=SETTLE_CYC; go to WAIT with busy=1.
REQ-019 xyw_out = idx in every state except IDLE, where it holds its last value.
REQ-020 WAIT: decrement the settle counter each cycle; after SETTLE_CYC cycles in WAIT, go to SAMPLE.
REQ-021 SAMPLE: capture f_in into tt_out[idx]; if f_in != eff_exp[idx], increment mism_cnt, and when err_valid=0 set first_err=idx and err_valid=1.
REQ-022 SAMPLE with idx<7: increment idx, reload the counter to SETTLE_CYC, return to WAIT; with idx==7: go to FIN.
REQ-023 Each minterm occupies exactly SETTLE_CYC+1 cycles, so the sweep spans 8*(SETTLE_CYC+1) cycles.
REQ-024 FIN (one cycle): done=1, busy=0, pass=(mism_cnt==0); next state IDLE.
REQ-025 In IDLE, tt_out, pass, mism_cnt, first_err and err_valid hold until the next accepted start.
REQ-026 start while busy=1 or in FIN is ignored and has no side effect.
REQ-027 exp_mask and pos_mode changes after start is accepted do not affect the running sweep.
REQ-028 abort in WAIT or SAMPLE: go to IDLE on the next edge with busy=0, done never pulses, pass=0; partial tt_out and mism_cnt are retained.
REQ-029 abort and SAMPLE in the same cycle: abort wins and the sample is discarded.
REQ-030 abort in IDLE or FIN has no effect.
REQ-031 mism_cnt is at most 8 and never wraps.

Reset
REQ-032 rst_n=0 forces immediately, independent of clk: state=IDLE, idx=0, xyw_out=0, busy=0, done=0, tt_out=0, pass=0, mism_cnt=0, first_err=0, err_valid=0.
REQ-033 Reset asserted mid-sweep discards the sweep and produces no done pulse.
REQ-034 Operation resumes on the first rising edge after rst_n deasserts; start sampled on that edge is honoured.

Verification
REQ-035 SETTLE_CYC=1, pos_mode=0, exp_mask=8'h35, f=(~x&~w)|(x&~y) -> xyw_out steps 0..7, 2 cycles each; done pulses 16 cycles after start; tt_out=8'h35, pass=1, mism_cnt=0, err_valid=0.
REQ-036 pos_mode=1, exp_mask=8'hCA, f=(x|~w)&(~x|~y) -> tt_out=8'h35, pass=1.
REQ-037 pos_mode=0, exp_mask=8'h35, f tied to 0 -> tt_out=8'h00, mism_cnt=4, first_err=0, err_valid=1, pass=0.
REQ-038 abort asserted while idx=3 -> busy falls on the next edge, no done pulse, pass=0; a following start runs a full clean sweep.
REQ-039 start held high through the whole sweep -> exactly one sweep and one done pulse per IDLE visit; rst_n pulsed low mid-sweep -> all outputs 0 asynchronously, no done.
REQ-040 SETTLE_CYC=3 -> each xyw_out value held 4 cycles; done pulses 32 cycles after start.
